// File: rtl/debug_disp_pkg.sv
// debug_disp_pkg: display mode encodings, blank pattern and hex-to-seven-segment table
package debug_disp_pkg;
  typedef enum logic [1:0] {MODE_PC = 2'd0, MODE_RS = 2'd1, MODE_RT = 2'd2, MODE_ALU = 2'd3} mode_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    return HEX_SEG[n];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser + stability counter on btn; db is the accepted level, step_pulse one cycle per accepted rise
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db,
  output logic step_pulse
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2, db_q, done;
  logic [W-1:0] dcnt;
  always_comb done = dcnt == W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      step_pulse <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      db_q <= db;
      step_pulse <= db & ~db_q;
      dcnt <= (s2 == db || done) ? '0 : dcnt + W'(1);
      if (s2 != db && done) db <= s2;
    end
  end
endmodule

// File: rtl/cpu_debug_display.sv
// cpu_debug_display: debounced CPU step clock (cpu_clk, step_pulse) + framed 4-digit hex scan (an, seg) of a sw_sel-chosen byte pair
module cpu_debug_display
  import debug_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_step,
  input  logic [1:0]  sw_sel,
  input  logic [31:0] pc,
  input  logic [31:0] pcIn,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] ALURes,
  input  logic [31:0] writeData,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);
  localparam int SW = $clog2(SCAN_CYCLES);
  logic [SW-1:0] scnt;
  logic [1:0] idx;
  logic [15:0] disp, sel;
  logic [3:0] nib;
  logic tick;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(CLK),
    .rst(RST),
    .btn(btn_step),
    .db(cpu_clk),
    .step_pulse(step_pulse)
  );
  always_comb begin
    sel = sw_sel == MODE_PC ? {pc[7:0], pcIn[7:0]} :
          sw_sel == MODE_RS ? {3'b000, rs, ReadData1[7:0]} :
          sw_sel == MODE_RT ? {3'b000, rt, ReadData2[7:0]} :
                              {ALURes[7:0], writeData[7:0]};
    tick = scnt == SW'(SCAN_CYCLES - 1);
    nib = disp[{idx, 2'b00} +: 4];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      scnt <= '0;
      idx <= 2'd0;
      disp <= 16'h0000;
      an <= 4'b1110;
      seg <= {1'b1, hex_seg(4'h0)};
    end else begin
      scnt <= tick ? '0 : scnt + SW'(1);
      idx <= idx + 2'(tick);
      if (tick && idx == 2'd3) disp <= sel;
      an <= ~(4'b0001 << idx);
      seg <= {1'b1, hex_seg(nib)};
    end
  end
endmodule

// File: tb/tb_cpu_debug_display.sv
// tb_cpu_debug_display: scoreboard bench for debounce timing and framed display scan
module tb_cpu_debug_display;
  logic CLK = 1'b0, RST = 1'b1, btn_step = 1'b0;
  logic [1:0] sw_sel = 2'd0;
  logic [31:0] pc = 32'h0, pcIn = 32'h0, ReadData1 = 32'h0, ReadData2 = 32'h0, ALURes = 32'h0, writeData = 32'h0;
  logic [4:0] rs = 5'd0, rt = 5'd0;
  logic cpu_clk, step_pulse;
  logic [3:0] an;
  logic [7:0] seg;
  always #5 CLK = ~CLK;
  cpu_debug_display #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3)) dut (
    .CLK(CLK), .RST(RST), .btn_step(btn_step), .sw_sel(sw_sel),
    .pc(pc), .pcIn(pcIn), .rs(rs), .rt(rt),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ALURes(ALURes), .writeData(writeData),
    .cpu_clk(cpu_clk), .step_pulse(step_pulse), .an(an), .seg(seg)
  );
  typedef struct {logic v; int c;} lvl_t;
  typedef struct {logic [3:0] an; logic [7:0] seg; int c;} dsp_t;
  lvl_t q_lvl[$];
  int q_pul[$];
  dsp_t q_dsp[$];
  lvl_t el;
  dsp_t ed;
  int ep;
  int cyc = 0, vecs = 0, errs = 0;
  bit mon_on = 0, dmon = 0;
  logic prev_clk;
  logic [3:0] prev_an;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic miss(input string name);
    vecs++;
    errs++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  task automatic dexp(input int c, input logic [3:0] a, input logic [7:0] s);
    ed.an = a;
    ed.seg = s;
    ed.c = c;
    q_dsp.push_back(ed);
  endtask
  task automatic lexp(input logic v, input int c);
    el.v = v;
    el.c = c;
    q_lvl.push_back(el);
  endtask
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (mon_on) begin
      if (cpu_clk !== prev_clk) begin
        if (q_lvl.size() == 0) miss("cpu_clk_unexpected_edge");
        else begin
          el = q_lvl.pop_front();
          chk("cpu_clk_level", {31'b0, cpu_clk}, {31'b0, el.v});
          chk("cpu_clk_cycle", cyc, el.c);
        end
      end
      if (step_pulse !== 1'b0) begin
        if (q_pul.size() == 0) miss("step_pulse_unexpected");
        else begin
          ep = q_pul.pop_front();
          chk("step_pulse_cycle", cyc, ep);
        end
      end
      if (dmon && an !== prev_an) begin
        if (q_dsp.size() == 0) miss("an_unexpected_change");
        else begin
          ed = q_dsp.pop_front();
          chk("an", {28'b0, an}, {28'b0, ed.an});
          chk("seg", {24'b0, seg}, {24'b0, ed.seg});
          chk("digit_cycle", cyc, ed.c);
        end
      end
    end
    prev_clk = cpu_clk;
    prev_an = an;
  end
  task automatic release_btn();
    @(negedge CLK);
    btn_step = 1'b0;
    lexp(1'b0, cyc + 6);
    repeat (12) @(negedge CLK);
  endtask
  initial begin
    int r, c;
    pc = 32'h0000_00A4;
    pcIn = 32'h0000_00A8;
    repeat (2) @(negedge CLK);
    chk("reset_cpu_clk", {31'b0, cpu_clk}, 32'd0);
    chk("reset_step_pulse", {31'b0, step_pulse}, 32'd0);
    chk("reset_an", {28'b0, an}, 32'b1110);
    chk("reset_seg", {24'b0, seg}, 32'hC0);
    RST = 1'b0;
    r = cyc;
    mon_on = 1;
    dmon = 1;
    dexp(r + 4, 4'b1101, 8'hC0);
    dexp(r + 7, 4'b1011, 8'hC0);
    dexp(r + 10, 4'b0111, 8'hC0);
    dexp(r + 13, 4'b1110, 8'h80);
    dexp(r + 16, 4'b1101, 8'h88);
    dexp(r + 19, 4'b1011, 8'h99);
    dexp(r + 22, 4'b0111, 8'h88);
    dexp(r + 25, 4'b1110, 8'h8E);
    dexp(r + 28, 4'b1101, 8'h86);
    dexp(r + 31, 4'b1011, 8'hA4);
    dexp(r + 34, 4'b0111, 8'hF9);
    dexp(r + 37, 4'b1110, 8'h8E);
    while (cyc < r + 16) @(negedge CLK);
    sw_sel = 2'd3;
    ALURes = 32'h0000_0012;
    writeData = 32'h0000_00EF;
    while (cyc < r + 38) @(negedge CLK);
    dmon = 0;
    c = cyc;
    btn_step = 1'b1;
    lexp(1'b1, c + 6);
    q_pul.push_back(c + 7);
    repeat (20) @(negedge CLK);
    release_btn();
    c = cyc;
    btn_step = 1'b1;
    @(negedge CLK) btn_step = 1'b0;
    @(negedge CLK) btn_step = 1'b1;
    @(negedge CLK) btn_step = 1'b0;
    @(negedge CLK) btn_step = 1'b1;
    lexp(1'b1, c + 10);
    q_pul.push_back(c + 11);
    repeat (20) @(negedge CLK);
    release_btn();
    c = cyc;
    btn_step = 1'b1;
    lexp(1'b1, c + 11);
    q_pul.push_back(c + 12);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    release_btn();
    mon_on = 0;
    while (q_lvl.size() != 0) begin
      el = q_lvl.pop_front();
      miss("cpu_clk_edge_missing");
    end
    while (q_pul.size() != 0) begin
      ep = q_pul.pop_front();
      miss("step_pulse_missing");
    end
    while (q_dsp.size() != 0) begin
      ed = q_dsp.pop_front();
      miss("digit_change_missing");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
